serial_transmitter: RTL



---
 rtl/serial_transmitter_if.sv | 9 +
 rtl/serial_transmitter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_transmitter_if.sv
// Valid/ready word handshake into the serial transmitter FIFO.
interface serial_transmitter_if;
  logic [6:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/serial_transmitter.sv
// Serial transmitter: buffers 7-bit words in a FIFO and sends each as
// start(0), D0..D6 LSB first, even parity, STOP_BITS high cycles.
// The line idles high and serial_out is registered.
module serial_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  serial_transmitter_if.slave           in_if,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One counter serves both the data-bit index (0..6) and the stop-cycle index.
  localparam int BIT_W = (STOP_BITS > 7) ? $clog2(STOP_BITS) + 1 : 3;

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(6);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              serial_out_q, serial_out_d;
  logic [6:0]        mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic [6:0] head;

  assign in_if.data_ready = (count_q != FULL);
  assign push             = in_if.data_valid && in_if.data_ready;
  assign head             = mem_q[rd_ptr_q];
  assign serial_out       = serial_out_q;
  assign busy             = (state_q != S_IDLE);
  assign fifo_count       = count_q;

  // FIFO storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.data_in;
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Framing FSM: pops the FIFO head in IDLE or on the final stop cycle so
  // frames run back-to-back; the line value is registered one cycle later.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    pop          = 1'b0;
    serial_out_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        serial_out_d = 1'b1;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = ^head;
          state_d  = S_START;
        end
      end
      S_START: begin
        serial_out_d = 1'b0;
        bit_cnt_d    = '0;
        state_d      = S_DATA;
      end
      S_DATA: begin
        serial_out_d = shift_q[0];
        shift_d      = shift_q >> 1;
        if (bit_cnt_q == LAST_DATA) begin
          state_d = S_PARITY;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_PARITY: begin
        serial_out_d = parity_q;
        bit_cnt_d    = '0;
        state_d      = S_STOP;
      end
      S_STOP: begin
        serial_out_d = 1'b1;
        if (bit_cnt_q == LAST_STOP) begin
          if (count_q != '0) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = ^head;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer and line registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      serial_out_q <= serial_out_d;
    end
  end

endmodule
